// File: rtl/factorial_ctrl.sv
// factorial_ctrl: sequencing controller for an iterative factorial.
// Runs acc = n * (n-1) * ... * 2 by issuing one multiply per step to an
// external multi-cycle multiplier over a mul_start/mul_done handshake.
module factorial_ctrl #(
    parameter int WIDTH = 64,
    parameter int NW    = 6,
    parameter int MAX_N = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [NW-1:0]    n_in,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_result,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [NW-1:0]    MAX_N_V = NW'(MAX_N);
    localparam logic [NW-1:0]    ONE_N   = NW'(1);
    localparam logic [NW-1:0]    TWO_N   = NW'(2);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [NW-1:0]    cnt_q, cnt_d;

    // State, accumulator and down-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; clear takes priority over a coincident mul_done.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_in > MAX_N_V) begin
                        state_d = S_ERROR;
                    end else if (n_in <= ONE_N) begin
                        acc_d   = ONE_W;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = ONE_W;
                        cnt_d   = n_in;
                        state_d = S_MUL_REQ;
                    end
                end
            end
            S_MUL_REQ: begin
                state_d = clear ? S_IDLE : S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else if (mul_done) begin
                    acc_d   = mul_result;
                    cnt_d   = cnt_q - ONE_N;
                    // The multiply just finished was by 2: nothing left to do.
                    state_d = (cnt_q == TWO_N) ? S_DONE : S_MUL_REQ;
                end
            end
            S_DONE, S_ERROR: begin
                if (clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state only, so an asynchronous
    // reset drives every output low immediately.
    always_comb begin
        mul_start = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        result    = '0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            S_MUL_REQ: begin
                mul_start = 1'b1;
                mul_a     = acc_q;
                mul_b     = WIDTH'(cnt_q);
                busy      = 1'b1;
            end
            S_MUL_WAIT: begin
                mul_a = acc_q;
                mul_b = WIDTH'(cnt_q);
                busy  = 1'b1;
            end
            S_DONE: begin
                done   = 1'b1;
                result = acc_q;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_factorial_ctrl.sv
// Testbench for factorial_ctrl: fixed-latency (L=3) multiplier model,
// per-cycle expectations derived from the factorial latency rules.
module tb_factorial_ctrl;

    localparam int WIDTH = 64;
    localparam int NW    = 6;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic [NW-1:0]    n_in = '0;
    logic             mul_start;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;
    logic [WIDTH-1:0] result;
    logic             busy, done, error;

    logic             mdl_done = 1'b0;
    logic [WIDTH-1:0] mdl_res = '0;
    logic             stray_done = 1'b0;

    int vectors = 0;
    int fails   = 0;

    logic [WIDTH-1:0] seen_a[$];
    logic [WIDTH-1:0] seen_b[$];

    assign mul_done   = mdl_done | stray_done;
    assign mul_result = mdl_done ? mdl_res : 64'hDEAD_BEEF_0BAD_F00D;

    factorial_ctrl #(.WIDTH(WIDTH), .NW(NW), .MAX_N(20)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .n_in(n_in),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .result(result), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Multiplier model: mul_done pulses LAT cycles after the mul_start cycle.
    always begin
        logic [WIDTH-1:0] ma, mb;
        @(negedge clk);
        if (mul_start) begin
            ma = mul_a;
            mb = mul_b;
            seen_a.push_back(ma);
            seen_b.push_back(mb);
            repeat (LAT) @(posedge clk);
            #1;
            mdl_done = 1'b1;
            mdl_res  = ma * mb;
            @(posedge clk);
            #1;
            mdl_done = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Status outputs are mutually exclusive at all times.
    always @(negedge clk) begin
        if (!reset) begin
            vectors++;
            if ((int'(busy) + int'(done) + int'(error)) > 1) begin
                fails++;
                $display("FAIL status_onehot: got busy=%0b done=%0b error=%0b expected at most one high",
                         busy, done, error);
            end
        end
    end

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, {63'd0, busy}, 64'd0);
        chk({name, "_done"}, {63'd0, done}, 64'd0);
        chk({name, "_error"}, {63'd0, error}, 64'd0);
        chk({name, "_mul_start"}, {63'd0, mul_start}, 64'd0);
        chk({name, "_result"}, result, 64'd0);
    endtask

    // Reference model: n! and the operands of the i-th multiply (0-based).
    function automatic logic [WIDTH-1:0] fact(input int n);
        logic [WIDTH-1:0] r = 64'd1;
        for (int k = 2; k <= n; k++) r = r * WIDTH'(k);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] pair_a(input int n, input int i);
        logic [WIDTH-1:0] r = 64'd1;
        for (int j = 0; j < i; j++) r = r * WIDTH'(n - j);
        return r;
    endfunction

    // One complete calculation from IDLE, checked every cycle, then clear.
    task automatic run_calc(input int n, output int first_done,
                            output logic [WIDTH-1:0] final_res);
        int dc;
        bit exp_ms;
        dc = (n <= 1) ? 1 : 1 + (n - 1) * (LAT + 1);
        first_done = -1;
        final_res = '0;
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = NW'(n);
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= dc; c++) begin
            @(negedge clk);
            exp_ms = (n >= 2) && (c < dc) && (((c - 1) % (LAT + 1)) == 0);
            chk($sformatf("n%0d_c%0d_mul_start", n, c), {63'd0, mul_start}, {63'd0, exp_ms});
            if (n >= 2 && c < dc) begin
                chk($sformatf("n%0d_c%0d_mul_a", n, c), mul_a, pair_a(n, (c - 1) / (LAT + 1)));
                chk($sformatf("n%0d_c%0d_mul_b", n, c), mul_b,
                    WIDTH'(n - (c - 1) / (LAT + 1)));
            end
            chk($sformatf("n%0d_c%0d_busy", n, c), {63'd0, busy}, {63'd0, (c < dc)});
            chk($sformatf("n%0d_c%0d_done", n, c), {63'd0, done}, {63'd0, (c == dc)});
            chk($sformatf("n%0d_c%0d_result", n, c), result, (c == dc) ? fact(n) : 64'd0);
            if (done && first_done < 0) first_done = c;
            if (c == dc) final_res = result;
            if (c < dc) begin
                @(posedge clk); #1;
            end
        end
        // start is ignored in DONE
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = NW'(3);
        @(negedge clk);
        chk($sformatf("n%0d_hold_done", n), {63'd0, done}, 64'd1);
        chk($sformatf("n%0d_hold_result", n), result, fact(n));
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk_idle($sformatf("n%0d_after_clear", n));
    endtask

    initial begin
        int fd;
        logic [WIDTH-1:0] res;
        bit found;

        // Reset state, before and after a clock edge
        #2;
        chk_idle("reset_pre");
        chk("reset_pre_mul_a", mul_a, 64'd0);
        chk("reset_pre_mul_b", mul_b, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_idle("reset_post");

        // n=5: literal operand sequence, latency and result
        seen_a.delete();
        seen_b.delete();
        run_calc(5, fd, res);
        chk("n5_done_cycle", WIDTH'(fd), 64'd17);
        chk("n5_result", res, 64'd120);
        chk("n5_mul_count", WIDTH'(seen_a.size()), 64'd4);
        if (seen_a.size() == 4) begin
            chk("n5_pair0_a", seen_a[0], 64'd1);  chk("n5_pair0_b", seen_b[0], 64'd5);
            chk("n5_pair1_a", seen_a[1], 64'd5);  chk("n5_pair1_b", seen_b[1], 64'd4);
            chk("n5_pair2_a", seen_a[2], 64'd20); chk("n5_pair2_b", seen_b[2], 64'd3);
            chk("n5_pair3_a", seen_a[3], 64'd60); chk("n5_pair3_b", seen_b[3], 64'd2);
        end

        // n=20: largest legal operand
        run_calc(20, fd, res);
        chk("n20_done_cycle", WIDTH'(fd), 64'd77);
        chk("n20_result", res, 64'h21C3677C82B40000);

        // n=0, n=1: no multiplies; n=2: single multiply
        seen_a.delete();
        run_calc(0, fd, res);
        chk("n0_done_cycle", WIDTH'(fd), 64'd1);
        chk("n0_result", res, 64'd1);
        run_calc(1, fd, res);
        chk("n1_done_cycle", WIDTH'(fd), 64'd1);
        chk("n1_result", res, 64'd1);
        chk("n01_no_mul", WIDTH'(seen_a.size()), 64'd0);
        run_calc(2, fd, res);
        chk("n2_done_cycle", WIDTH'(fd), 64'd5);
        chk("n2_result", res, 64'd2);

        // n=21: error, start held while in ERROR, then clear
        seen_a.delete();
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = NW'(21);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("n21_c%0d_error", c), {63'd0, error}, 64'd1);
            chk($sformatf("n21_c%0d_result", c), result, 64'd0);
            chk($sformatf("n21_c%0d_busy", c), {63'd0, busy}, 64'd0);
            chk($sformatf("n21_c%0d_mul_start", c), {63'd0, mul_start}, 64'd0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        chk("n21_error_until_edge", {63'd0, error}, 64'd1);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk_idle("n21_after_clear");
        chk("n21_no_mul", WIDTH'(seen_a.size()), 64'd0);
        run_calc(3, fd, res);
        chk("n3_result", res, 64'd6);

        // n=6: clear coincident with mul_done in MUL_WAIT
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = NW'(6);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mul_done) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        vectors++;
        if (!found) begin
            fails++;
            $display("FAIL abort_wait_mul_done: got timeout expected mul_done within 12 cycles");
        end
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        seen_a.delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_idle($sformatf("abort_c%0d", c));
            @(posedge clk); #1;
        end
        chk("abort_no_more_mul", WIDTH'(seen_a.size()), 64'd0);
        // Stray mul_done in IDLE
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle($sformatf("stray_c%0d", c));
            @(posedge clk); #1;
        end

        // n=10: asynchronous reset mid-MUL_WAIT
        start = 1'b1;
        n_in  = NW'(10);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_mid_busy", {63'd0, busy}, 64'd1);
        chk("rst_mid_mul_start", {63'd0, mul_start}, 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("rst_async");
        chk("rst_async_mul_a", mul_a, 64'd0);
        chk("rst_async_mul_b", mul_b, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk_idle("rst_release");
        run_calc(4, fd, res);
        chk("n4_result", res, 64'd24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
